// File: rtl/memory_dp_be.sv
// True dual-port single-clock RAM with byte-lane write enables, per-port write mode,
// a 0-2 stage valid-tagged output pipeline and a hardware clear sequencer.
module memory_dp_be #(
    parameter int unsigned RAM_WIDTH      = 16,
    parameter int unsigned RAM_DEPTH      = 1024,
    parameter int unsigned BYTE_W         = 8,
    parameter int unsigned OUT_REGS       = 1,
    parameter string       WRITE_MODE_A   = "WRITE_FIRST",
    parameter string       WRITE_MODE_B   = "WRITE_FIRST",
    parameter int unsigned CLEAR_ON_RESET = 1,
    localparam int unsigned NB = RAM_WIDTH / BYTE_W,
    localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    output logic                 busy_o,
    input  logic                 ena_i,
    input  logic [NB-1:0]        wea_i,
    input  logic [AW-1:0]        addra_i,
    input  logic [RAM_WIDTH-1:0] dina_i,
    output logic [RAM_WIDTH-1:0] douta_o,
    output logic                 valida_o,
    input  logic                 enb_i,
    input  logic [NB-1:0]        web_i,
    input  logic [AW-1:0]        addrb_i,
    input  logic [RAM_WIDTH-1:0] dinb_i,
    output logic [RAM_WIDTH-1:0] doutb_o,
    output logic                 validb_o
);

    localparam logic [1:0] ModeWf = 2'd0;
    localparam logic [1:0] ModeRf = 2'd1;
    localparam logic [1:0] ModeNc = 2'd2;
    localparam logic [1:0] ModeA  = (WRITE_MODE_A == "READ_FIRST") ? ModeRf :
                                    (WRITE_MODE_A == "NO_CHANGE")  ? ModeNc : ModeWf;
    localparam logic [1:0] ModeB  = (WRITE_MODE_B == "READ_FIRST") ? ModeRf :
                                    (WRITE_MODE_B == "NO_CHANGE")  ? ModeNc : ModeWf;

    typedef enum logic [1:0] {StReset, StClear, StReady} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            busy;

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // Port index 0 is A, 1 is B.
    logic [1:0]           en;
    logic [NB-1:0]        we     [2];
    logic [AW-1:0]        addr   [2];
    logic [RAM_WIDTH-1:0] din    [2];
    logic [1:0]           mode   [2];
    logic [1:0]           acc;
    logic [NB-1:0]        wr     [2];
    logic [RAM_WIDTH-1:0] rd_old [2];
    logic [RAM_WIDTH-1:0] rd_mrg [2];
    logic [1:0]           v0;
    logic [RAM_WIDTH-1:0] d0     [2];
    logic                 same_addr;

    logic [RAM_WIDTH-1:0] pd_q [2][OUT_REGS+1];
    logic [OUT_REGS:0]    pv_q [2];

    assign en[0]   = ena_i;
    assign en[1]   = enb_i;
    assign we[0]   = wea_i;
    assign we[1]   = web_i;
    assign addr[0] = addra_i;
    assign addr[1] = addrb_i;
    assign din[0]  = dina_i;
    assign din[1]  = dinb_i;
    assign mode[0] = ModeA;
    assign mode[1] = ModeB;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StReset;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StReset: begin
                cnt_d   = '0;
                state_d = (CLEAR_ON_RESET != 0) ? StClear : StReady;
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(RAM_DEPTH - 1)) state_d = StReady;
            end
            StReady: begin
                if (clr_i) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        busy = (state_q == StClear);
    end

    assign busy_o = busy;

    // ---------------- access decode ----------------
    assign same_addr = (addr[0] == addr[1]);

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            acc[p]    = en[p] & ~busy & (32'(addr[p]) < RAM_DEPTH);
            wr[p]     = acc[p] ? we[p] : '0;
            rd_old[p] = mem[addr[p]];
            rd_mrg[p] = rd_old[p];
            for (int i = 0; i < int'(NB); i++) begin
                if (we[p][i]) rd_mrg[p][i*BYTE_W +: BYTE_W] = din[p][i*BYTE_W +: BYTE_W];
            end
            // NO_CHANGE writes leave the array register and valid untouched.
            v0[p] = acc[p] & ~((|wr[p]) & (mode[p] == ModeNc));
            d0[p] = ((|wr[p]) && (mode[p] == ModeWf)) ? rd_mrg[p] : rd_old[p];
        end
    end

    // ---------------- array ----------------
    always_ff @(posedge clk_i) begin
        if (state_q == StClear) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < int'(NB); i++) begin
                // On a shared address, port A owns every lane it enables.
                if (wr[1][i] && !(same_addr && wr[0][i]))
                    mem[addr[1]][i*BYTE_W +: BYTE_W] <= din[1][i*BYTE_W +: BYTE_W];
                if (wr[0][i])
                    mem[addr[0]][i*BYTE_W +: BYTE_W] <= din[0][i*BYTE_W +: BYTE_W];
            end
        end
    end

    // ---------------- output pipeline ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < 2; p++) begin
                pv_q[p] <= '0;
                for (int s = 0; s <= int'(OUT_REGS); s++) pd_q[p][s] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                pv_q[p][0] <= v0[p];
                if (v0[p]) pd_q[p][0] <= d0[p];
                for (int s = 1; s <= int'(OUT_REGS); s++) begin
                    pv_q[p][s] <= pv_q[p][s-1];
                    if (pv_q[p][s-1]) pd_q[p][s] <= pd_q[p][s-1];
                end
            end
        end
    end

    assign douta_o  = pd_q[0][OUT_REGS];
    assign valida_o = pv_q[0][OUT_REGS];
    assign doutb_o  = pd_q[1][OUT_REGS];
    assign validb_o = pv_q[1][OUT_REGS];

endmodule

// File: tb/tb_memory_dp_be.sv
// Directed bench: three 16-word instances sharing stimulus, differing in port A mode and
// output depth (idx 0: NO_CHANGE/0 regs, 1: WRITE_FIRST/1 reg, 2: READ_FIRST/2 regs).
module tb_memory_dp_be;

    logic        clk, rst_n, clr;
    logic        ena, enb;
    logic [1:0]  wea, web;
    logic [3:0]  addra, addrb;
    logic [15:0] dina, dinb;
    logic [15:0] douta [3];
    logic [15:0] doutb [3];
    logic        va [3];
    logic        vb [3];
    logic        busy [3];

    int checks = 0;
    int errors = 0;
    int step   = 0;

    typedef struct packed {
        logic             ena;
        logic [1:0]       wea;
        logic [3:0]       addra;
        logic [15:0]      dina;
        logic             enb;
        logic [1:0]       web;
        logic [3:0]       addrb;
        logic [15:0]      dinb;
        logic [2:0][15:0] ea;
        logic [2:0]       vae;
        logic [15:0]      eb;
        logic             vbe;
    } vec_t;

    vec_t tbl [15];

    memory_dp_be #(.RAM_DEPTH(16), .OUT_REGS(0), .WRITE_MODE_A("NO_CHANGE")) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy[0]),
        .ena_i(ena), .wea_i(wea), .addra_i(addra), .dina_i(dina),
        .douta_o(douta[0]), .valida_o(va[0]),
        .enb_i(enb), .web_i(web), .addrb_i(addrb), .dinb_i(dinb),
        .doutb_o(doutb[0]), .validb_o(vb[0])
    );

    memory_dp_be #(.RAM_DEPTH(16), .OUT_REGS(1), .WRITE_MODE_A("WRITE_FIRST")) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy[1]),
        .ena_i(ena), .wea_i(wea), .addra_i(addra), .dina_i(dina),
        .douta_o(douta[1]), .valida_o(va[1]),
        .enb_i(enb), .web_i(web), .addrb_i(addrb), .dinb_i(dinb),
        .doutb_o(doutb[1]), .validb_o(vb[1])
    );

    memory_dp_be #(.RAM_DEPTH(16), .OUT_REGS(2), .WRITE_MODE_A("READ_FIRST")) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy[2]),
        .ena_i(ena), .wea_i(wea), .addra_i(addra), .dina_i(dina),
        .douta_o(douta[2]), .valida_o(va[2]),
        .enb_i(enb), .web_i(web), .addrb_i(addrb), .dinb_i(dinb),
        .doutb_o(doutb[2]), .validb_o(vb[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string nm, input int r, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d step %0d: got %h, expected %h", nm, r, step, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int r, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d step %0d: got %b, expected %b", nm, r, step, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ea_en, input logic [1:0] a_we, input logic [3:0] a_ad,
                                input logic [15:0] a_d, input logic eb_en, input logic [1:0] b_we,
                                input logic [3:0] b_ad, input logic [15:0] b_d,
                                input logic [15:0] ea0, input logic [15:0] ea1,
                                input logic [15:0] ea2, input logic va0, input logic va1,
                                input logic va2, input logic [15:0] eb, input logic vbx);
        vec_t v;
        v.ena = ea_en;  v.wea = a_we;  v.addra = a_ad;  v.dina = a_d;
        v.enb = eb_en;  v.web = b_we;  v.addrb = b_ad;  v.dinb = b_d;
        v.ea[0] = ea0;  v.ea[1] = ea1;  v.ea[2] = ea2;
        v.vae = {va2, va1, va0};
        v.eb = eb;  v.vbe = vbx;
        return v;
    endfunction

    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0; clr = 1'b0;
        addra = '0; addrb = '0; dina = '0; dinb = '0;
    endtask

    // Present one access for one cycle; instance r must answer exactly r+1 cycles later.
    task automatic apply(input vec_t v);
        ena = v.ena; wea = v.wea; addra = v.addra; dina = v.dina;
        enb = v.enb; web = v.web; addrb = v.addrb; dinb = v.dinb;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) idle();
            for (int r = 0; r < 3; r++) begin
                chk1("VALIDA", r, va[r], (k == r + 1) ? v.vae[r] : 1'b0);
                chk1("VALIDB", r, vb[r], (k == r + 1) ? v.vbe : 1'b0);
                if (k == r + 1) begin
                    chk16("DOUTA", r, douta[r], v.ea[r]);
                    chk16("DOUTB", r, doutb[r], v.eb);
                end
            end
        end
        step++;
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 16; i++)
            apply(mk(1'b1, 2'b00, 4'(i), 16'h0, 1'b1, 2'b00, 4'(15 - i), 16'h0,
                     16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1));
    endtask

    // Caller sits at the first negedge that should show BUSY; stops at the first idle one.
    task automatic count_busy(output int n);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (!busy[1]) break;
            n++;
            @(negedge clk);
        end
    endtask

    int nbusy;

    initial begin
        //          ena we    aa    dina     enb we    ab    dinb     ea0      ea1      ea2      va0..2        eb       vb
        tbl[0]  = mk(1, 2'b11, 4'd5, 16'hBEEF, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 0, 1, 1, 16'h0000, 0);
        tbl[1]  = mk(0, 2'b00, 4'd0, 16'h0000, 1, 2'b00, 4'd5, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 0, 16'hBEEF, 1);
        tbl[2]  = mk(1, 2'b11, 4'd3, 16'h1234, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 0, 1, 1, 16'hBEEF, 0);
        tbl[3]  = mk(1, 2'b01, 4'd3, 16'hABCD, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 16'h12CD, 16'h1234, 0, 1, 1, 16'hBEEF, 0);
        tbl[4]  = mk(1, 2'b00, 4'd3, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 16'h12CD, 16'h12CD, 16'h12CD, 1, 1, 1, 16'hBEEF, 0);
        tbl[5]  = mk(1, 2'b11, 4'd7, 16'h1111, 1, 2'b11, 4'd7, 16'h2222, 16'h12CD, 16'h1111, 16'h0000, 0, 1, 1, 16'h2222, 1);
        tbl[6]  = mk(1, 2'b00, 4'd7, 16'h0000, 1, 2'b00, 4'd7, 16'h0000, 16'h1111, 16'h1111, 16'h1111, 1, 1, 1, 16'h1111, 1);
        tbl[7]  = mk(1, 2'b10, 4'd8, 16'h1111, 1, 2'b11, 4'd8, 16'h2222, 16'h1111, 16'h1100, 16'h0000, 0, 1, 1, 16'h2222, 1);
        tbl[8]  = mk(1, 2'b00, 4'd8, 16'h0000, 1, 2'b00, 4'd8, 16'h0000, 16'h1122, 16'h1122, 16'h1122, 1, 1, 1, 16'h1122, 1);
        tbl[9]  = mk(1, 2'b11, 4'd9, 16'h3333, 1, 2'b00, 4'd9, 16'h0000, 16'h1122, 16'h3333, 16'h0000, 0, 1, 1, 16'h0000, 1);
        tbl[10] = mk(1, 2'b00, 4'd9, 16'h0000, 1, 2'b00, 4'd9, 16'h0000, 16'h3333, 16'h3333, 16'h3333, 1, 1, 1, 16'h3333, 1);
        tbl[11] = mk(1, 2'b11, 4'd2, 16'h5A5A, 0, 2'b00, 4'd0, 16'h0000, 16'h3333, 16'h5A5A, 16'h0000, 0, 1, 1, 16'h3333, 0);
        tbl[12] = mk(1, 2'b00, 4'd2, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 16'h5A5A, 16'h5A5A, 16'h5A5A, 1, 1, 1, 16'h3333, 0);
        tbl[13] = mk(0, 2'b11, 4'd2, 16'hFFFF, 0, 2'b11, 4'd2, 16'hFFFF, 16'h5A5A, 16'h5A5A, 16'h5A5A, 0, 0, 0, 16'h3333, 0);
        tbl[14] = mk(1, 2'b00, 4'd2, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 16'h5A5A, 16'h5A5A, 16'h5A5A, 1, 1, 1, 16'h3333, 0);

        idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            chk1("BUSY_RST", r, busy[r], 1'b0);
            chk1("VALIDA_RST", r, va[r], 1'b0);
            chk16("DOUTA_RST", r, douta[r], 16'h0);
            chk16("DOUTB_RST", r, doutb[r], 16'h0);
        end

        // Clear after reset release lasts exactly DEPTH cycles.
        rst_n = 1'b1;
        @(negedge clk);
        count_busy(nbusy);
        chk16("BUSY_LEN_INIT", 1, 16'(nbusy), 16'd16);
        read_all_zero();

        for (int i = 0; i < 15; i++) apply(tbl[i]);

        // Reset in clear cycle 5: outputs drop at once, clear restarts in full.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        chk1("BUSY_MIDCLR", 1, busy[1], 1'b1);
        rst_n = 1'b0;
        #1;
        for (int r = 0; r < 3; r++) begin
            chk1("BUSY_ABORT", r, busy[r], 1'b0);
            chk1("VALIDA_ABORT", r, va[r], 1'b0);
            chk16("DOUTA_ABORT", r, douta[r], 16'h0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        count_busy(nbusy);
        chk16("BUSY_LEN_RESTART", 1, 16'(nbusy), 16'd16);
        apply(mk(1'b1, 2'b00, 4'd2, 16'h0, 1'b1, 2'b00, 4'd9, 16'h0,
                 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1));

        // CLR with port A hammering writes: none land, no VALIDA.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        nbusy = 0;
        for (int c = 0; c < 200; c++) begin
            for (int r = 0; r < 3; r++) chk1("VALIDA_BUSY", r, va[r], 1'b0);
            if (!busy[1]) break;
            nbusy++;
            ena = 1'b1; wea = 2'b11; dina = 16'hFFFF; addra = 4'(c);
            @(negedge clk);
        end
        idle();
        chk16("BUSY_LEN_CLR", 1, 16'(nbusy), 16'd16);
        read_all_zero();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_dp_be.md
Name: memory_dp_be

Overview:
Parametrised true dual-port, single-clock RAM with per-byte write enables and a per-port write mode (WRITE_FIRST / READ_FIRST / NO_CHANGE). It has a 0–2 stage output pipeline with valid strobes, defined same-address collision handling, and a hardware clear sequencer that zeroes the array after reset or on request. It is the sample/event buffer primitive for the digitizer readout path and replaces the plain dual-port RAM in new designs.

Parameters:
RAM_WIDTH, 16, data word width in bits; must be a multiple of BYTE_W.
RAM_DEPTH, 1024, number of words.
BYTE_W, 8, bits per write-enable lane; NB = RAM_WIDTH/BYTE_W.
OUT_REGS, 1, output pipeline stages after the array register (0, 1 or 2).
WRITE_MODE_A, "WRITE_FIRST", port A mode: "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
WRITE_MODE_B, "WRITE_FIRST", port B mode, same encoding as WRITE_MODE_A.
CLEAR_ON_RESET, 1, 1 = zero the array after reset release; 0 = go straight to READY.

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
CLR  in  1  synchronous clear request; single-cycle pulse, honoured only in READY
BUSY  out  1  high while the clear sequence runs; port requests are ignored
ENA  in  1  port A access enable
WEA  in  NB  port A byte write enables (meaningful only when ENA=1)
ADDRA  in  AW  port A address; AW = max(1, clog2(RAM_DEPTH))
DINA  in  RAM_WIDTH  port A write data
DOUTA  out  RAM_WIDTH  port A read data
VALIDA  out  1  DOUTA carries fresh data this cycle
ENB, WEB, ADDRB, DINB, DOUTB, VALIDB  same widths and meaning for port B

Behaviour:
- Reset: asynchronous and active-low. While RST_N=0: all DOUT/VALID regs = 0, BUSY = 0, FSM = RESET. The array contents are not reset.
- FSM states:
  - RESET: on the first clock after release, go to CLEAR if CLEAR_ON_RESET=1, else to READY.
  - CLEAR: BUSY=1. Write zeros to the address counter, 0 up to RAM_DEPTH-1, one word per cycle, exactly RAM_DEPTH cycles. On the last address go to READY. CLR is ignored in this state.
  - READY: BUSY=0. CLR=1 sends the FSM to CLEAR with the counter set to 0.
- When BUSY=1, ENA and ENB are treated as 0: no writes, no VALID pulses, no queueing.
- Accepted access: ENx=1 and not BUSY. A write occurs if WEx≠0, and only lanes with WEx[i]=1 are updated. Addresses ≥ RAM_DEPTH (when DEPTH is not a power of 2) are ignored and produce no VALID.
- Array register output per port, per mode:
  - Read (WEx=0): the stored word.
  - WRITE_FIRST write: the merged word (new bytes in enabled lanes, old bytes elsewhere).
  - READ_FIRST write: the old word.
  - NO_CHANGE write: the register holds and no VALID is produced.
- ENx=0: the array register holds.
- Latency: DOUTx/VALIDx appear 1+OUT_REGS cycles after the accepting edge. VALIDx is a 1-cycle pulse per producing access. Pipeline regs advance every cycle (no stall), and each stage's data loads only when its valid bit is set, so DOUT holds the last valid value.
- Collision (both ports accepted, same address):
  - A and B both write: port A's enabled lanes win; B's lanes not covered by WEA are written.
  - One port writes, the other reads: the reader returns the old word.
  - Reading ports see the same data as without the collision. No error output.
- Reset mid-clear: clear aborts and restarts from address 0 after release (if CLEAR_ON_RESET=1).
- Reset mid-pipeline: in-flight VALIDs are dropped.

Test Plan:
1. DEPTH=16, CLEAR_ON_RESET=1: release RST_N → BUSY=1 for exactly 16 cycles. Then read all 16 addresses → every DOUT=0x0000 with VALID after 2 cycles (OUT_REGS=1).
2. Write A addr 5 = 0xBEEF, then read B addr 5 → DOUTB=0xBEEF, VALIDB exactly 2 cycles after the read edge. With OUT_REGS=0 the latency is 1; with OUT_REGS=2 it is 3.
3. Byte enable: addr 3 holds 0x1234; write A WEA=2'b01 DINA=0xABCD → WRITE_FIRST DOUTA=0x12CD, then read → 0x12CD. With READ_FIRST the write returns 0x1234. With NO_CHANGE there is no VALIDA and DOUTA is unchanged.
4. Same-cycle collision at addr 7: A writes 0x1111 with WEA=2'b11, B writes 0x2222 with WEB=2'b11 → later read returns 0x1111. Repeat with WEA=2'b10 → 0x1122. Repeat with A write and B read of old 0x0000 → DOUTB=0x0000.
5. Issue CLR in READY with ENA=1 writes each cycle → BUSY for DEPTH cycles, no VALIDA, no writes land; all words read 0 afterwards.
6. Assert RST_N low at clear cycle 5 for 3 cycles → outputs and VALID drop to 0 immediately. After release, BUSY lasts a full DEPTH cycles again.
